// File: rtl/lampfpu_log_postnorm_pkg.sv
// Shared constants and stage payload types for the bfloat16 log post-normalisation.
// Flag indices follow the FPU status register layout {NV,DZ,OF,UF,NX}.
package lampfpu_log_postnorm_pkg;

  localparam int LAMP_FLOAT_DW   = 16;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;

  localparam logic [15:0] LAMP_FLOAT_QNAN    = 16'h7FC0;
  localparam logic [15:0] LAMP_FLOAT_PINF    = 16'h7F80;
  localparam logic [15:0] LAMP_FLOAT_NINF    = 16'hFF80;
  localparam logic [7:0]  LAMP_FLOAT_EXP_MAX = 8'hFF;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [6:0]  frac;
    logic        inc;
    logic        ovf;
    logic        unf;
    logic        special;
    logic [15:0] specialVal;
    logic [4:0]  flags;
  } s1_t;

endpackage

// File: rtl/lampfpu_log_postnorm_rndneareven.sv
// Applies a round-to-nearest-even increment to a bfloat16 mantissa.
// A mantissa carry clears the fraction and bumps the 9-bit exponent.
module lampfpu_log_postnorm_rndneareven
  import lampfpu_log_postnorm_pkg::*;
(
  input  logic [LAMP_FLOAT_F_DW-1:0] i_frac,
  input  logic [LAMP_FLOAT_E_DW-1:0] i_exp,
  input  logic                       i_inc,
  output logic [LAMP_FLOAT_F_DW-1:0] o_frac,
  output logic [LAMP_FLOAT_E_DW:0]   o_exp
);

  logic [LAMP_FLOAT_F_DW:0] w_sum;

  always_comb begin
    w_sum  = {1'b0, i_frac} + {{LAMP_FLOAT_F_DW{1'b0}}, i_inc};
    o_frac = w_sum[LAMP_FLOAT_F_DW] ? '0 : w_sum[LAMP_FLOAT_F_DW-1:0];
    o_exp  = {1'b0, i_exp}
           + {{LAMP_FLOAT_E_DW{1'b0}}, w_sum[LAMP_FLOAT_F_DW]};
  end

endmodule

// File: rtl/lampfpu_log_postnorm.sv
// Log post-normalisation: special-case resolution, RNE rounding, range checks,
// two-stage valid/ready pipeline and sticky exception flags.
module lampfpu_log_postnorm
  import lampfpu_log_postnorm_pkg::*;
#(
  parameter int DW         = 16,
  parameter int FRAC_IN_DW = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  s_i,
  input  logic [7:0]            e_i,
  input  logic [FRAC_IN_DW-1:0] f_i,
  input  logic                  isOverflow_i,
  input  logic                  isUnderflow_i,
  input  logic                  s_op_i,
  input  logic                  isZ_op_i,
  input  logic                  isInf_op_i,
  input  logic                  isSNAN_op_i,
  input  logic                  isQNAN_op_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DW-1:0]         res_o,
  output logic [4:0]            flags_o,
  input  logic                  clr_flags_i
);

  logic          r_v1;
  logic          r_v2;
  s1_t           r_s1;
  logic [DW-1:0] r_res;
  logic [4:0]    r_flg2;
  logic [4:0]    r_flags;

  logic          w_adv1;
  logic          w_adv2;
  s1_t           w_s1;
  logic [6:0]    w_frac;
  logic [8:0]    w_exp;
  logic [DW-1:0] w_res;
  logic [4:0]    w_flg;

  assign w_adv2  = ~r_v2 | ready_i;
  assign w_adv1  = ~r_v1 | w_adv2;
  assign ready_o = w_adv1;
  assign valid_o = r_v2;
  assign res_o   = r_res;
  assign flags_o = r_flags;

  always_comb begin
    w_s1 = '0;
    w_s1.sign = s_i;
    w_s1.exp  = e_i;
    w_s1.frac = f_i[9:3];
    w_s1.inc  = f_i[2] & (f_i[1] | f_i[0] | f_i[3]);
    w_s1.ovf  = isOverflow_i;
    w_s1.unf  = isUnderflow_i;
    w_s1.flags[FLAG_NX] = |f_i[2:0];
    priority case (1'b1)
      isSNAN_op_i | isQNAN_op_i: begin
        w_s1.special    = 1'b1;
        w_s1.specialVal = LAMP_FLOAT_QNAN;
        w_s1.flags      = '0;
        w_s1.flags[FLAG_NV] = isSNAN_op_i;
      end
      s_op_i & ~isZ_op_i: begin
        w_s1.special    = 1'b1;
        w_s1.specialVal = LAMP_FLOAT_QNAN;
        w_s1.flags      = '0;
        w_s1.flags[FLAG_NV] = 1'b1;
      end
      isZ_op_i: begin
        w_s1.special    = 1'b1;
        w_s1.specialVal = LAMP_FLOAT_NINF;
        w_s1.flags      = '0;
        w_s1.flags[FLAG_DZ] = 1'b1;
      end
      isInf_op_i: begin
        w_s1.special    = 1'b1;
        w_s1.specialVal = LAMP_FLOAT_PINF;
        w_s1.flags      = '0;
      end
      default: ;
    endcase
  end

  lampfpu_log_postnorm_rndneareven u_rnd (
    .i_frac (r_s1.frac),
    .i_exp  (r_s1.exp),
    .i_inc  (r_s1.inc),
    .o_frac (w_frac),
    .o_exp  (w_exp)
  );

  // A carry out of 0xFE lands on 0xFF or beyond: both saturate to infinity
  always_comb begin
    w_res = {r_s1.sign, w_exp[7:0], w_frac};
    w_flg = '0;
    w_flg[FLAG_NX] = r_s1.flags[FLAG_NX];
    if (r_s1.special) begin
      w_res = r_s1.specialVal;
      w_flg = r_s1.flags;
    end else if (r_s1.ovf || (w_exp >= {1'b0, LAMP_FLOAT_EXP_MAX})) begin
      w_res = {r_s1.sign, LAMP_FLOAT_EXP_MAX, 7'd0};
      w_flg[FLAG_OF] = 1'b1;
      w_flg[FLAG_NX] = 1'b1;
    end else if (r_s1.unf || (r_s1.exp == 8'd0)) begin
      w_res = {r_s1.sign, 15'd0};
      w_flg[FLAG_UF] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_s1    <= '0;
      r_res   <= '0;
      r_flg2  <= '0;
      r_flags <= '0;
    end else begin
      if (w_adv1) begin
        r_v1 <= valid_i;
        if (valid_i) r_s1 <= w_s1;
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_res  <= w_res;
          r_flg2 <= w_flg;
        end
      end
      if (clr_flags_i) r_flags <= '0;
      else if (r_v2 & ready_i) r_flags <= r_flags | r_flg2;
    end
  end

endmodule
